// File: rtl/nios2_secure_memory_cpu_mult_pkg.sv
// rtl/nios2_secure_memory_cpu_mult_pkg.sv - op encodings and stage payload for the multiplier pipe
package nios2_secure_memory_cpu_mult_pkg;

    // Widest tag the stage payload can carry; the top keeps only the low TAG_W bits.
    localparam int unsigned TAG_MAX_W = 16;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULXSS = 2'b01,
        OP_MULXSU = 2'b10,
        OP_MULXUU = 2'b11
    } op_e;

    typedef struct packed {
        logic                 valid;
        op_e                  op;
        logic [TAG_MAX_W-1:0] tag;
        logic                 sign_a;
        logic                 sign_b;
        logic                 acc_op;
        logic                 acc_clr;
    } stage_t;

    // Operand A is treated as signed for every op except MULXUU.
    function automatic logic op_sign_a(input logic [1:0] op, input logic msb);
        return (op != OP_MULXUU) && msb;
    endfunction

    // Operand B is treated as signed only for MULXSS.
    function automatic logic op_sign_b(input logic [1:0] op, input logic msb);
        return (op == OP_MULXSS) && msb;
    endfunction

endpackage

// File: rtl/nios2_secure_memory_cpu_cpu_mult_pp.sv
// rtl/nios2_secure_memory_cpu_cpu_mult_pp.sv - registered HWxHW unsigned partial-product multiplier
module nios2_secure_memory_cpu_cpu_mult_pp #(
    parameter int HW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [HW-1:0] a,
    input  logic [HW-1:0] b,
    output logic [2*HW-1:0] p
);

    // Unsigned product, widened before multiplying so no bits are lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            p <= '0;
        end else if (en) begin
            p <= {{HW{1'b0}}, a} * {{HW{1'b0}}, b};
        end
    end

endmodule

// File: rtl/nios2_secure_memory_cpu_cpu_mult_pipe.sv
// rtl/nios2_secure_memory_cpu_cpu_mult_pipe.sv - pipelined MUL/MULX multiplier; NIOS2_SECURE_MEMORY_MULT_ACC_EN adds an accumulator
module nios2_secure_memory_cpu_cpu_mult_pipe
    import nios2_secure_memory_cpu_mult_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int PIPE_STAGES = 3,
    parameter int TAG_W       = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              in_valid,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              acc_op,
    input  logic              acc_clr,
    output logic              out_valid,
    output logic [DATA_W-1:0] result,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int HW  = DATA_W / 2;
    localparam int PW  = 2 * DATA_W;
    localparam int DLY = PIPE_STAGES - 3;

    stage_t               s1_ctl, s2_ctl;
    logic [DATA_W-1:0]    s1_a, s1_b, s2_a, s2_b;
    logic [TAG_MAX_W-1:0] tag_ext;
    logic [DATA_W-1:0]    pp_ll, pp_lh, pp_hl, pp_hh;
    logic [PW-1:0]        prod, full;
    logic                 sum_valid;
    logic [TAG_MAX_W-1:0] sum_tag;
    logic [DATA_W-1:0]    sum_word;
    logic                 fin_valid;
    logic [TAG_MAX_W-1:0] fin_tag;
    logic [DATA_W-1:0]    fin_word;
    logic                 unused_tag_bits;

    // Zero-extend the caller's tag into the payload field.
    always_comb begin
        tag_ext            = '0;
        tag_ext[TAG_W-1:0] = in_tag;
    end

    // Stage 1: capture operands and decode sign handling for the op.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_ctl <= '0;
            s1_a   <= '0;
            s1_b   <= '0;
        end else if (en) begin
            s1_ctl.valid   <= in_valid;
            s1_ctl.op      <= op_e'(op);
            s1_ctl.tag     <= tag_ext;
            s1_ctl.sign_a  <= op_sign_a(op, src1[DATA_W-1]);
            s1_ctl.sign_b  <= op_sign_b(op, src2[DATA_W-1]);
            s1_ctl.acc_op  <= acc_op;
            s1_ctl.acc_clr <= acc_clr;
            s1_a           <= src1;
            s1_b           <= src2;
        end
    end

    // Stage 2: four half-width unsigned partial products.
    nios2_secure_memory_cpu_cpu_mult_pp #(.HW(HW)) u_pp_ll (
        .clk(clk), .reset(reset), .en(en), .a(s1_a[HW-1:0]),      .b(s1_b[HW-1:0]),      .p(pp_ll));
    nios2_secure_memory_cpu_cpu_mult_pp #(.HW(HW)) u_pp_lh (
        .clk(clk), .reset(reset), .en(en), .a(s1_a[HW-1:0]),      .b(s1_b[DATA_W-1:HW]), .p(pp_lh));
    nios2_secure_memory_cpu_cpu_mult_pp #(.HW(HW)) u_pp_hl (
        .clk(clk), .reset(reset), .en(en), .a(s1_a[DATA_W-1:HW]), .b(s1_b[HW-1:0]),      .p(pp_hl));
    nios2_secure_memory_cpu_cpu_mult_pp #(.HW(HW)) u_pp_hh (
        .clk(clk), .reset(reset), .en(en), .a(s1_a[DATA_W-1:HW]), .b(s1_b[DATA_W-1:HW]), .p(pp_hh));

    // Stage 2 payload: full operands are kept for the sign correction.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_ctl <= '0;
            s2_a   <= '0;
            s2_b   <= '0;
        end else if (en) begin
            s2_ctl <= s1_ctl;
            s2_a   <= s1_a;
            s2_b   <= s1_b;
        end
    end

    // Stage 3 sum: unsigned product, then subtract the two's-complement weight of negative operands.
    always_comb begin
        prod = {pp_hh, pp_ll}
             + {{HW{1'b0}}, pp_lh, {HW{1'b0}}}
             + {{HW{1'b0}}, pp_hl, {HW{1'b0}}};
        if (s2_ctl.sign_a) prod = prod - {s2_b, {DATA_W{1'b0}}};
        if (s2_ctl.sign_b) prod = prod - {s2_a, {DATA_W{1'b0}}};
    end

`ifdef NIOS2_SECURE_MEMORY_MULT_ACC_EN
    logic [PW-1:0] acc, acc_next;
    logic          acc_use;

    // New accumulator value; clear-and-load wins over accumulate.
    always_comb begin
        acc_use  = s2_ctl.acc_clr | s2_ctl.acc_op;
        acc_next = s2_ctl.acc_clr ? prod : acc + prod;
        full     = acc_use ? acc_next : prod;
    end

    // Accumulator updates only when a valid op passes the sum stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (en && s2_ctl.valid && acc_use) begin
            acc <= acc_next;
        end
    end
`else
    logic unused_acc_bits;
    assign unused_acc_bits = s2_ctl.acc_op ^ s2_ctl.acc_clr;

    // Without the accumulator the product feeds the word select directly.
    always_comb begin
        full = prod;
    end
`endif

    // Word select: MUL returns the low half, all MULX forms the high half.
    always_comb begin
        sum_valid = s2_ctl.valid;
        sum_tag   = s2_ctl.tag;
        sum_word  = (s2_ctl.op == OP_MUL) ? full[DATA_W-1:0] : full[PW-1:DATA_W];
    end

    generate
        if (DLY > 0) begin : g_delay
            logic [DLY-1:0]       v_q;
            logic [TAG_MAX_W-1:0] tag_q  [DLY];
            logic [DATA_W-1:0]    word_q [DLY];

            // Output retiming: shift the sum-stage payload toward the output register.
            always_ff @(posedge clk) begin
                if (reset) begin
                    v_q <= '0;
                    for (int i = 0; i < DLY; i++) begin
                        tag_q[i]  <= '0;
                        word_q[i] <= '0;
                    end
                end else if (en) begin
                    v_q[0]    <= sum_valid;
                    tag_q[0]  <= sum_tag;
                    word_q[0] <= sum_word;
                    for (int i = 1; i < DLY; i++) begin
                        v_q[i]    <= v_q[i-1];
                        tag_q[i]  <= tag_q[i-1];
                        word_q[i] <= word_q[i-1];
                    end
                end
            end

            assign fin_valid = v_q[DLY-1];
            assign fin_tag   = tag_q[DLY-1];
            assign fin_word  = word_q[DLY-1];
        end else begin : g_direct
            assign fin_valid = sum_valid;
            assign fin_tag   = sum_tag;
            assign fin_word  = sum_word;
        end
    endgenerate

    assign unused_tag_bits = ^fin_tag;

    // Output register: result/tag load only for a valid op; out_valid follows the final valid bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            out_tag   <= '0;
        end else if (en) begin
            out_valid <= fin_valid;
            if (fin_valid) begin
                result  <= fin_word;
                out_tag <= fin_tag[TAG_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_nios2_secure_memory_cpu_cpu_mult_pipe.sv
// tb/tb_nios2_secure_memory_cpu_cpu_mult_pipe.sv - scoreboard bench for the multiplier pipe
module tb_nios2_secure_memory_cpu_cpu_mult_pipe;

    localparam int DATA_W      = 32;
    localparam int PIPE_STAGES = 3;
    localparam int TAG_W       = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              en;
    logic              in_valid;
    logic [1:0]        op;
    logic [DATA_W-1:0] src1, src2;
    logic [TAG_W-1:0]  in_tag;
    logic              acc_op, acc_clr;
    logic              out_valid;
    logic [DATA_W-1:0] result;
    logic [TAG_W-1:0]  out_tag;

    typedef struct {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] res;
        int                due;
    } exp_t;

    exp_t              sb_q[$];
    logic [DATA_W-1:0] cur_exp;
    int                ecnt    = 0;
    int                n_tests = 0;
    int                n_fail  = 0;

    always #5 clk = ~clk;

    nios2_secure_memory_cpu_cpu_mult_pipe #(
        .DATA_W(DATA_W), .PIPE_STAGES(PIPE_STAGES), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .op(op),
        .src1(src1), .src2(src2), .in_tag(in_tag), .acc_op(acc_op), .acc_clr(acc_clr),
        .out_valid(out_valid), .result(result), .out_tag(out_tag)
    );

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference product using full 64-bit multiplies of sign/zero-extended operands.
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        case (o)
            2'b01:   p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            2'b10:   p = {{32{a[31]}}, a} * {32'b0, b};
            default: p = {32'b0, a} * {32'b0, b};
        endcase
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Each call defines the inputs for one clock cycle.
    task automatic drive(input logic e, input logic v, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] t, input logic ao, input logic ac,
                         input logic [31:0] x);
        @(posedge clk); #1;
        en = e; in_valid = v; op = o; src1 = a; src2 = b; in_tag = t;
        acc_op = ao; acc_clr = ac; cur_exp = x;
    endtask

    task automatic idle(input logic e);
        drive(e, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);
    endtask

    // Push the expectation when the DUT samples an op; due is the enabled-cycle count at output.
    always @(posedge clk) begin
        if (reset) begin
            sb_q.delete();
            ecnt = 0;
        end else if (en) begin
            ecnt++;
            if (in_valid) sb_q.push_back('{tag: in_tag, res: cur_exp, due: ecnt + PIPE_STAGES - 1});
        end
    end

    // Pop and compare once per unstalled cycle with out_valid set.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && en) begin
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_out_valid", {63'b0, out_valid}, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("out_tag", {59'b0, out_tag}, {59'b0, e.tag});
                    check_eq("result", {32'b0, result}, {32'b0, e.res});
                    check_eq("latency", ecnt, e.due);
                end
            end else if (sb_q.size() != 0 && sb_q[0].due <= ecnt) begin
                check_eq("missing_out_valid", {63'b0, out_valid}, 64'd1);
                e = sb_q.pop_front();
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic        e_r, v_r;
        logic [1:0]  o_r;
        logic [31:0] a_r, b_r;

        reset = 1'b1; en = 1'b0; in_valid = 1'b0; op = 2'b00; src1 = '0; src2 = '0;
        in_tag = '0; acc_op = 1'b0; acc_clr = 1'b0; cur_exp = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_out_valid", {63'b0, out_valid}, 64'd0);
        check_eq("reset_result", {32'b0, result}, 64'd0);
        check_eq("reset_out_tag", {59'b0, out_tag}, 64'd0);
        reset = 1'b0;

        // 1) basic MUL
        drive(1, 1, 2'b00, 32'h0001_0003, 32'h0000_0005, 5'd7, 0, 0, 32'h0005_000F);
        repeat (4) idle(1);

        // 2) high-word forms of -1 / 0xFFFFFFFF back-to-back
        drive(1, 1, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 0, 0, 32'h0000_0000);
        drive(1, 1, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0, 0, 32'hFFFF_FFFF);
        drive(1, 1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 0, 0, 32'hFFFF_FFFE);
        repeat (4) idle(1);

        // 3) stall in mid-flight, then stall while the result is presented
        drive(1, 1, 2'b00, 32'd6, 32'd7, 5'd9, 0, 0, 32'h0000_002A);
        idle(1);
        for (int i = 0; i < 5; i++) begin
            idle(0);
            @(negedge clk);
            check_eq("stall_no_out_valid", {63'b0, out_valid}, 64'd0);
            check_eq("stall_result_hold", {32'b0, result}, 64'hFFFF_FFFE);
        end
        idle(1);
        for (int i = 0; i < 2; i++) begin
            idle(0);
            @(negedge clk);
            check_eq("stall_valid_held", {63'b0, out_valid}, 64'd1);
            check_eq("stall_result_held", {32'b0, result}, 64'h2A);
        end
        repeat (3) idle(1);

        // 4) bubble between ops 2 and 3
        drive(1, 1, 2'b00, 32'd10, 32'd3, 5'd1, 0, 0, 32'd30);
        drive(1, 1, 2'b00, 32'd11, 32'd3, 5'd2, 0, 0, 32'd33);
        idle(1);
        drive(1, 1, 2'b00, 32'd12, 32'd3, 5'd3, 0, 0, 32'd36);
        drive(1, 1, 2'b00, 32'd13, 32'd3, 5'd4, 0, 0, 32'd39);
        repeat (4) idle(1);

        // 5) reset with two ops in flight
        drive(1, 1, 2'b00, 32'd100, 32'd100, 5'd5, 0, 0, 32'd10000);
        drive(1, 1, 2'b00, 32'd200, 32'd200, 5'd6, 0, 0, 32'd40000);
        idle(1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_eq("midreset_out_valid", {63'b0, out_valid}, 64'd0);
        check_eq("midreset_result", {32'b0, result}, 64'd0);
        check_eq("midreset_out_tag", {59'b0, out_tag}, 64'd0);
        repeat (4) idle(1);
        drive(1, 1, 2'b00, 32'h0000_1234, 32'h0000_0010, 5'd11, 0, 0, 32'h0001_2340);
        repeat (4) idle(1);

        // 6) accumulator load then accumulate
        drive(1, 1, 2'b00, 32'd3, 32'd4, 5'd12, 0, 1, 32'h0000_000C);
`ifdef NIOS2_SECURE_MEMORY_MULT_ACC_EN
        drive(1, 1, 2'b00, 32'd5, 32'd6, 5'd13, 1, 0, 32'h0000_002A);
`else
        drive(1, 1, 2'b00, 32'd5, 32'd6, 5'd13, 1, 0, 32'h0000_001E);
`endif
        repeat (4) idle(1);

        // Random ops, bubbles and stalls against the reference model
        for (int i = 0; i < 300; i++) begin
            e_r = ($urandom_range(0, 4) != 0);
            v_r = ($urandom_range(0, 3) != 0);
            o_r = 2'($urandom_range(0, 3));
            a_r = pick();
            b_r = pick();
            drive(e_r, v_r, o_r, a_r, b_r, 5'($urandom_range(0, 31)), 0, 0, model(o_r, a_r, b_r));
        end
        repeat (8) idle(1);
        @(negedge clk);
        check_eq("drain_empty", sb_q.size(), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
